// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// result_o = {remainder, quotient}; start/ready handshake with annul for pipeline flush.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     dvd_q;
   logic [WIDTH-1:0]     dsr_q;
   logic                 neg1_q;
   logic                 neg2_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 ready_q;

   logic [WIDTH-1:0]     abs1_d;
   logic [WIDTH-1:0]     abs2_d;
   logic [WIDTH:0]       upper_d;
   logic [WIDTH:0]       trial_d;
   logic [WIDTH-1:0]     quot_d;
   logic [WIDTH-1:0]     rem_d;

   // Magnitudes of the operands; the sign flags below restore the signs at the end.
   assign abs1_d  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign abs2_d  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   assign upper_d = {rem_q, dvd_q[WIDTH-1]};
   assign trial_d = upper_d - {1'b0, dsr_q};
   assign quot_d  = (neg1_q ^ neg2_q) ? -dvd_q : dvd_q;
   assign rem_d   = neg1_q ? -rem_q : rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            FREE: begin
               result_q <= '0;
               ready_q  <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state_q <= BY_ZERO;
                  end else begin
                     state_q <= ON;
                     neg1_q  <= signed_div_i & opdata1_i[WIDTH-1];
                     neg2_q  <= signed_div_i & opdata2_i[WIDTH-1];
                     dvd_q   <= abs1_d;
                     dsr_q   <= abs2_d;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                  end
               end
            end
            BY_ZERO: begin
               state_q  <= END;
               result_q <= '0;
            end
            ON: begin
               if (annul_i) begin
                  state_q  <= FREE;
                  result_q <= '0;
                  ready_q  <= 1'b0;
               end else if (cnt_q != CNT_LAST) begin
                  // The quotient bit shifts into the dividend register as it empties.
                  if (!trial_d[WIDTH]) begin
                     rem_q <= trial_d[WIDTH-1:0];
                     dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_q <= upper_d[WIDTH-1:0];
                     dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                  end
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  result_q <= {rem_d, quot_d};
                  ready_q  <= 1'b1;
                  state_q  <= END;
               end
            end
            END: begin
               if (start_i) begin
                  ready_q <= 1'b1;
               end else begin
                  state_q  <= FREE;
                  ready_q  <= 1'b0;
                  result_q <= '0;
               end
            end
            default: state_q <= FREE;
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq at WIDTH=32 and WIDTH=8
// Randomized operands are checked against an arithmetic reference model.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        s32, start32, annul32, ready32;
   logic [31:0] a32, b32;
   logic [63:0] result32;
   logic        s8, start8, annul8, ready8;
   logic [7:0]  a8, b8;
   logic [15:0] result8;

   int tests_run;
   int tests_failed;

   div_seq #(.WIDTH(32)) u_div32 (
      .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
      .start_i(start32), .annul_i(annul32), .result_o(result32), .ready_o(ready32)
   );

   div_seq #(.WIDTH(8)) u_div8 (
      .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
      .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {remainder, quotient} of a w-bit division, truncating toward zero.
   function automatic logic [63:0] ref_div(input int w, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] m, qq, rr;
      if (b == 0) return 64'd0;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      q  = sa / sb;
      r  = sa % sb;
      m  = (64'd1 << w) - 64'd1;
      qq = 64'(q) & m;
      rr = 64'(r) & m;
      return (rr << w) | qq;
   endfunction

   // Called at a negedge; leaves start high and returns at the negedge where ready is seen.
   task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int n);
      s32 = s; a32 = a; b32 = b; start32 = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!ready32 && n < 200);
      res = result32;
   endtask

   task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output int n);
      s8 = s; a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!ready8 && n < 200);
      res = result8;
   endtask

   task automatic drop32();
      start32 = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drop8();
      start8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (ready32 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready32: got %b expected 0", ready32); end
      tests_run++;
      if (result32 !== 64'd0) begin tests_failed++; $display("FAIL reset_result32: got %h expected 0", result32); end
      tests_run++;
      if (ready8 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready8: got %b expected 0", ready8); end
      tests_run++;
      if (result8 !== 16'd0) begin tests_failed++; $display("FAIL reset_result8: got %h expected 0", result8); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed32();
      logic        cs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] ca [5] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000};
      logic [31:0] cb [5] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF};
      logic [63:0] ce [5] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                              64'h00000001_FFFFFFFD, 64'h00000001_7FFFFFFC,
                              64'h00000000_80000000};
      logic [63:0] res;
      int n;
      for (int i = 0; i < 5; i++) begin
         run32(cs[i], ca[i], cb[i], res, n);
         tests_run++;
         if (n !== 33) begin tests_failed++; $display("FAIL dir32_latency[%0d]: got %0d expected 33", i, n); end
         tests_run++;
         if (res !== ce[i]) begin tests_failed++; $display("FAIL dir32_result[%0d]: got %h expected %h", i, res, ce[i]); end
         drop32();
         tests_run++;
         if (ready32 !== 1'b0 || result32 !== 64'd0) begin
            tests_failed++;
            $display("FAIL dir32_drop[%0d]: got ready=%b result=%h expected ready=0 result=0", i, ready32, result32);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [63:0] res;
      int n;
      for (int s = 0; s < 2; s++) begin
         run32(s[0], 32'h12345678, 32'd0, res, n);
         tests_run++;
         if (n !== 2) begin tests_failed++; $display("FAIL divzero_latency[%0d]: got %0d expected 2", s, n); end
         tests_run++;
         if (res !== 64'd0) begin tests_failed++; $display("FAIL divzero_result[%0d]: got %h expected 0", s, res); end
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (ready32 !== 1'b1 || result32 !== 64'd0) begin
               tests_failed++;
               $display("FAIL divzero_hold[%0d/%0d]: got ready=%b result=%h expected ready=1 result=0", s, k, ready32, result32);
            end
         end
         drop32();
      end
   endtask

   task automatic test_annul();
      logic [63:0] res;
      int n;
      s32 = 1'b0; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (ready32 !== 1'b0 || result32 !== 64'd0) begin
         tests_failed++;
         $display("FAIL annul_abort: got ready=%b result=%h expected ready=0 result=0", ready32, result32);
      end
      a32 = 32'd9; b32 = 32'd3;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         tests_run++;
         if (ready32 !== 1'b0) begin tests_failed++; $display("FAIL annul_block[%0d]: got ready=%b expected 0", k, ready32); end
      end
      annul32 = 1'b0;
      run32(1'b0, 32'd9, 32'd3, res, n);
      tests_run++;
      if (n !== 33) begin tests_failed++; $display("FAIL annul_restart_latency: got %0d expected 33", n); end
      tests_run++;
      if (res !== 64'h00000000_00000003) begin tests_failed++; $display("FAIL annul_restart_result: got %h expected 3", res); end
      drop32();
   endtask

   task automatic test_sync_reset();
      logic [63:0] res;
      int n;
      s32 = 1'b0; a32 = 32'd12345; b32 = 32'd67; start32 = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start32 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (ready32 !== 1'b0 || result32 !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_on: got ready=%b result=%h expected ready=0 result=0", ready32, result32);
      end
      rst = 1'b0;
      @(negedge clk);
      run32(1'b0, 32'd555, 32'd5, res, n);
      rst = 1'b1; start32 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (ready32 !== 1'b0 || result32 !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_in_end: got ready=%b result=%h expected ready=0 result=0", ready32, result32);
      end
      rst = 1'b0;
      @(negedge clk);
      run32(1'b0, 32'd1, 32'd1, res, n);
      tests_run++;
      if (n !== 33 || res !== 64'h00000000_00000001) begin
         tests_failed++;
         $display("FAIL reset_recover: got latency=%0d result=%h expected latency=33 result=1", n, res);
      end
      drop32();
   endtask

   task automatic test_width8();
      logic [15:0] res;
      int n;
      run8(1'b0, 8'd100, 8'd7, res, n);
      tests_run++;
      if (n !== 9 || res !== 16'h020E) begin
         tests_failed++;
         $display("FAIL w8_unsigned: got latency=%0d result=%h expected latency=9 result=020e", n, res);
      end
      drop8();
      run8(1'b1, 8'hF9, 8'd2, res, n);
      tests_run++;
      if (n !== 9 || res !== 16'hFFFD) begin
         tests_failed++;
         $display("FAIL w8_signed: got latency=%0d result=%h expected latency=9 result=fffd", n, res);
      end
      drop8();
   endtask

   task automatic test_random();
      logic [63:0] res, exp;
      logic [15:0] res8, exp8;
      logic [31:0] a, b;
      logic        s;
      int n;
      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom_range(0, 1));
         a = (i % 7 == 3) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFFFFFF;
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         exp = ref_div(32, s, a, b);
         run32(s, a, b, res, n);
         tests_run++;
         if (res !== exp || n !== ((b == 0) ? 2 : 33)) begin
            tests_failed++;
            $display("FAIL rand32[%0d] s=%b %h/%h: got latency=%0d result=%h expected %h", i, s, a, b, n, res, exp);
         end
         drop32();
      end
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 255));
         b = (i % 9 == 4) ? 32'd0 : ((i % 5 == 2) ? 32'hFF : 32'($urandom_range(0, 255)));
         exp  = ref_div(8, s, a, b);
         exp8 = exp[15:0];
         run8(s, a[7:0], b[7:0], res8, n);
         tests_run++;
         if (res8 !== exp8 || n !== ((b == 0) ? 2 : 9)) begin
            tests_failed++;
            $display("FAIL rand8[%0d] s=%b %h/%h: got latency=%0d result=%h expected %h", i, s, a[7:0], b[7:0], n, res8, exp8);
         end
         drop8();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] res, exp;
      logic [31:0] a, b;
      int n;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom >> (i * 8);
         if (b == 0) b = 32'd3;
         exp = ref_div(32, i[0], a, b);
         run32(i[0], a, b, res, n);
         tests_run++;
         if (res !== exp || n !== 33) begin
            tests_failed++;
            $display("FAIL b2b[%0d]: got latency=%0d result=%h expected latency=33 result=%h", i, n, res, exp);
         end
         start32 = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      s32 = 1'b0; a32 = '0; b32 = '0; start32 = 1'b0; annul32 = 1'b0;
      s8 = 1'b0; a8 = '0; b8 = '0; start8 = 1'b0; annul8 = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed32();
      test_div_zero();
      test_annul();
      test_sync_reset();
      test_width8();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle restoring divider for the execute stage. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, at one quotient bit per clock. It talks to EX through a start/ready handshake so EX can stall the pipeline, and EX can annul it on a flush. Its result feeds the HI/LO write path: remainder goes to HI, quotient to LO.

## Interface
- WIDTH, 32, operand width in bits; any value of 2 or more is legal.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = two's-complement division, 0 = unsigned; sampled only when start is accepted.
- opdata1_i  in  WIDTH  dividend; sampled only when start is accepted.
- opdata2_i  in  WIDTH  divisor; sampled only when start is accepted.
- start_i  in  1  request. EX holds it high until it sees ready_o, then drops it.
- annul_i  in  1  abort the operation in flight (pipeline flush).
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered.
- ready_o  out  1  result_o valid; registered.

## Operation
- States: FREE, BY_ZERO, ON, END. A step counter runs 0..WIDTH.
- Reset: state=FREE, counter=0, result_o=0, ready_o=0. A reset in any state, including mid-division, returns to these values on the next edge.
- FREE
  - start_i=1, annul_i=0, opdata2_i=0: go to BY_ZERO.
  - start_i=1, annul_i=0, opdata2_i≠0: go to ON.
    - Latch signed_div_i and the operand signs.
    - Load |opdata1_i| and |opdata2_i| (magnitudes only when signed_div_i=1; raw operands otherwise).
    - Clear the partial remainder and set counter=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BY_ZERO: on the next edge, go to END with quotient=0 and remainder=0.
- ON, annul_i=1: go to FREE; result_o=0, ready_o=0. Annul takes priority over a step and over completion.
- ON, counter<WIDTH: perform one restoring step.
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - counter++.
- ON, counter==WIDTH: apply sign correction, register result_o, set ready_o=1, go to END.
- Sign correction (signed_div_i=1 only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH. The most negative value divided by -1 yields quotient = most negative value and remainder 0; no trap is raised.
- END, start_i=1: hold; ready_o=1 and result_o stays stable.
- END, start_i=0: go to FREE; ready_o=0 and result_o=0 on that edge.
- annul_i in FREE, BY_ZERO or END has no effect beyond what start_i dictates. In FREE, annul_i=1 blocks acceptance of start_i.

## Timing
- Start is accepted on edge E0, when FREE samples start_i=1.
- Normal operation: steps occur on E1..E_WIDTH. ready_o rises after E_(WIDTH+1), which is 33 edges for WIDTH=32.
- Divide by zero: ready_o rises after E2.
- ready_o and result_o change only on clock edges and have no combinational path from any input.
- After start_i falls in END, FREE is reached on the next edge. A new start_i can be accepted on the edge after that, so the minimum issue interval is WIDTH+3 cycles.
- An annul sampled on any ON edge returns the block to FREE on that same edge. A new start can be accepted on the following edge.

## Test plan
- Unsigned 100/7, WIDTH=32, start held: ready_o rises exactly 33 edges after acceptance; result_o=0x00000002_0000000E. Drop start: ready_o=0 and result_o=0 one edge later.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Signed 7/-2: result_o=0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2: result_o=0x00000001_7FFFFFFC.
- Divide by zero, signed and unsigned, opdata1=0x12345678: ready_o after 2 edges; result_o=0. A held start keeps END for 5 cycles with stable outputs.
- Signed 0x80000000 / 0xFFFFFFFF: result_o=0x00000000_80000000 after 33 edges.
- Annul for one cycle at step 10:
  - FREE next edge; ready_o never rises.
  - A new start (9/3) on the following edge gives result_o=0x00000000_00000003 after 33 edges.
  - start_i with annul_i=1 in FREE is ignored.
- Synchronous reset pulsed mid-ON (step 20) and in END: next edge shows ready_o=0 and result_o=0. A subsequent 1/1 division completes normally with result_o=0x00000000_00000001.
- Repeat the 100/7 and -7/2 cases with WIDTH=8; ready_o after 9 edges. Results: 0x020E and 0xFFFD.
